// File: rtl/rv_iopmp_pkg.sv
// Shared types for the IOPMP BRAM arbiter: arbitration state and read-data owner encoding.
package rv_iopmp_pkg;

    typedef enum logic {
        ST_NORMAL    = 1'b0,
        ST_CFG_FORCE = 1'b1
    } arb_state_e;

    // Which requester the BRAM read data of the next cycle belongs to
    typedef enum logic [1:0] {
        OWNER_NONE = 2'b00,
        OWNER_LK   = 2'b01,
        OWNER_CFG  = 2'b10
    } owner_e;

endpackage

// File: rtl/rv_iopmp_bram_arbiter.sv
// Two-port arbiter sharing one IOPMP entry BRAM between the cfg path and the entry walker.
// Optional perf counter of conflict cycles is built only with RV_IOPMP_BRAM_ARB_PERF_EN.
module rv_iopmp_bram_arbiter
    import rv_iopmp_pkg::*;
#(
    parameter int NUMBER_ENTRIES = 8,
    parameter int BRAM_DWIDTH    = 128,
    parameter int MAX_STALL      = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_i,

    input  logic                              cfg_en_i,
    input  logic                              cfg_we_i,
    input  logic [$clog2(NUMBER_ENTRIES)-1:0] cfg_addr_i,
    input  logic [BRAM_DWIDTH-1:0]            cfg_din_i,
    input  logic [BRAM_DWIDTH/8-1:0]          cfg_be_i,
    output logic                              cfg_gnt_o,
    output logic                              cfg_rvalid_o,
    output logic [BRAM_DWIDTH-1:0]            cfg_rdata_o,

    input  logic                              lk_req_i,
    input  logic [$clog2(NUMBER_ENTRIES)-1:0] lk_addr_i,
    output logic                              lk_gnt_o,
    output logic                              lk_rvalid_o,
    output logic [BRAM_DWIDTH-1:0]            lk_rdata_o,

    output logic                              bram_en_o,
    output logic                              bram_we_o,
    output logic [$clog2(NUMBER_ENTRIES)-1:0] bram_addr_o,
    output logic [BRAM_DWIDTH-1:0]            bram_din_o,
    output logic [BRAM_DWIDTH/8-1:0]          bram_be_o,
    input  logic [BRAM_DWIDTH-1:0]            bram_dout_i,

    output logic [31:0]                       conflict_cnt_o
);

    localparam int STALL_W = $clog2(MAX_STALL + 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(MAX_STALL);

    arb_state_e         state;
    owner_e             owner;
    logic [STALL_W-1:0] stall_cnt;
    logic [STALL_W-1:0] stall_nxt;
    logic               cfg_gnt;
    logic               lk_gnt;

    // Lookup has priority until cfg has been starved for MAX_STALL cycles
    always_comb begin
        cfg_gnt = !rst_i && cfg_en_i && (state == ST_CFG_FORCE || !lk_req_i);
        lk_gnt  = !rst_i && lk_req_i && !cfg_gnt;
    end

    always_comb begin
        stall_nxt = stall_cnt;
        if (!cfg_en_i || cfg_gnt) begin
            stall_nxt = '0;
        end else if (stall_cnt != STALL_MAX) begin
            stall_nxt = stall_cnt + STALL_W'(1);
        end
    end

    always_comb begin
        bram_en_o   = 1'b0;
        bram_we_o   = 1'b0;
        bram_addr_o = '0;
        bram_din_o  = '0;
        bram_be_o   = '0;
        if (lk_gnt) begin
            bram_en_o   = 1'b1;
            bram_addr_o = lk_addr_i;
        end else if (cfg_gnt) begin
            bram_en_o   = 1'b1;
            bram_we_o   = cfg_we_i;
            bram_addr_o = cfg_addr_i;
            bram_din_o  = cfg_din_i;
            bram_be_o   = cfg_be_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_NORMAL;
            stall_cnt <= '0;
            owner     <= OWNER_NONE;
        end else begin
            stall_cnt <= stall_nxt;
            case (state)
                ST_NORMAL:    if (stall_nxt == STALL_MAX) state <= ST_CFG_FORCE;
                ST_CFG_FORCE: if (cfg_gnt) state <= ST_NORMAL;
                default:      state <= ST_NORMAL;
            endcase
            if (lk_gnt) begin
                owner <= OWNER_LK;
            end else if (cfg_gnt && !cfg_we_i) begin
                owner <= OWNER_CFG;
            end else begin
                owner <= OWNER_NONE;
            end
        end
    end

    // Gating with rst_i drops a response that was in flight when reset arrived
    assign lk_rvalid_o  = !rst_i && (owner == OWNER_LK);
    assign cfg_rvalid_o = !rst_i && (owner == OWNER_CFG);
    assign lk_rdata_o   = bram_dout_i;
    assign cfg_rdata_o  = bram_dout_i;
    assign cfg_gnt_o    = cfg_gnt;
    assign lk_gnt_o     = lk_gnt;

`ifdef RV_IOPMP_BRAM_ARB_PERF_EN
    logic [31:0] conflict_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            conflict_cnt <= '0;
        end else if (cfg_en_i && lk_req_i) begin
            conflict_cnt <= conflict_cnt + 32'd1;
        end
    end

    assign conflict_cnt_o = conflict_cnt;
`else
    assign conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_rv_iopmp_bram_arbiter.sv
// Self-checking bench for rv_iopmp_bram_arbiter: behavioural arbitration model plus read-response scoreboard.
module tb_rv_iopmp_bram_arbiter;

    localparam int NE = 8;
    localparam int DW = 128;
    localparam int MS = 4;
    localparam int AW = 3;
    localparam int BW = 16;

    logic          clk;
    logic          rst;
    logic          cfg_en, cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_din;
    logic [BW-1:0] cfg_be;
    logic          cfg_gnt, cfg_rvalid;
    logic [DW-1:0] cfg_rdata;
    logic          lk_req;
    logic [AW-1:0] lk_addr;
    logic          lk_gnt, lk_rvalid;
    logic [DW-1:0] lk_rdata;
    logic          bram_en, bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic [BW-1:0] bram_be;
    logic [DW-1:0] bram_dout;
    logic [31:0]   conflict_cnt;

    rv_iopmp_bram_arbiter #(
        .NUMBER_ENTRIES(NE),
        .BRAM_DWIDTH   (DW),
        .MAX_STALL     (MS)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cfg_en_i      (cfg_en),
        .cfg_we_i      (cfg_we),
        .cfg_addr_i    (cfg_addr),
        .cfg_din_i     (cfg_din),
        .cfg_be_i      (cfg_be),
        .cfg_gnt_o     (cfg_gnt),
        .cfg_rvalid_o  (cfg_rvalid),
        .cfg_rdata_o   (cfg_rdata),
        .lk_req_i      (lk_req),
        .lk_addr_i     (lk_addr),
        .lk_gnt_o      (lk_gnt),
        .lk_rvalid_o   (lk_rvalid),
        .lk_rdata_o    (lk_rdata),
        .bram_en_o     (bram_en),
        .bram_we_o     (bram_we),
        .bram_addr_o   (bram_addr),
        .bram_din_o    (bram_din),
        .bram_be_o     (bram_be),
        .bram_dout_i   (bram_dout),
        .conflict_cnt_o(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          lk_v;
        logic          cfg_v;
        logic [DW-1:0] data;
    } resp_t;

    resp_t         sb[$];
    logic [DW-1:0] mem[NE];
    logic [DW-1:0] shadow[NE];
    int            checks = 0;
    int            errors = 0;
    bit            m_force = 1'b0;
    int            m_stall = 0;
    logic [31:0]   m_conf = '0;
    bit            g_lk, g_cfg;

    function automatic logic [DW-1:0] initWord(input int i);
        return {4{32'hA000_0000 + 32'(i) * 32'h0101_0101}};
    endfunction

    // Registered-read BRAM with byte enables, standing in for the real block RAM
    always @(posedge clk) begin
        if (bram_en === 1'b1) begin
            if (bram_we) begin
                for (int b = 0; b < BW; b++)
                    if (bram_be[b]) mem[bram_addr][b*8 +: 8] <= bram_din[b*8 +: 8];
            end else begin
                bram_dout <= mem[bram_addr];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic ce, input logic cw, input logic [AW-1:0] ca,
                                 input logic [DW-1:0] cd, input logic [BW-1:0] cb,
                                 input logic lr, input logic [AW-1:0] la);
        resp_t resp;
        int    nxt;
        @(negedge clk);
        rst = r; cfg_en = ce; cfg_we = cw; cfg_addr = ca; cfg_din = cd; cfg_be = cb;
        lk_req = lr; lk_addr = la;
        #1;
        if (sb.size() > 0) begin
            resp = sb.pop_front();
            if (r) begin
                resp.lk_v  = 1'b0;
                resp.cfg_v = 1'b0;
            end
            checkOutput("lk_rvalid", DW'(lk_rvalid), DW'(resp.lk_v));
            checkOutput("cfg_rvalid", DW'(cfg_rvalid), DW'(resp.cfg_v));
            if (resp.lk_v) checkOutput("lk_rdata", lk_rdata, resp.data);
            if (resp.cfg_v) checkOutput("cfg_rdata", cfg_rdata, resp.data);
        end
        g_cfg = !r && ce && (m_force || !lr);
        g_lk  = !r && lr && !g_cfg;
        checkOutput("lk_gnt", DW'(lk_gnt), DW'(g_lk));
        checkOutput("cfg_gnt", DW'(cfg_gnt), DW'(g_cfg));
        checkOutput("bram_en", DW'(bram_en), DW'(g_lk || g_cfg));
        if (g_lk) begin
            checkOutput("bram_addr_lk", DW'(bram_addr), DW'(la));
            checkOutput("bram_we_lk", DW'(bram_we), '0);
            checkOutput("bram_be_lk", DW'(bram_be), '0);
        end else if (g_cfg) begin
            checkOutput("bram_addr_cfg", DW'(bram_addr), DW'(ca));
            checkOutput("bram_we_cfg", DW'(bram_we), DW'(cw));
            if (cw) begin
                checkOutput("bram_be_cfg", DW'(bram_be), DW'(cb));
                checkOutput("bram_din_cfg", bram_din, cd);
            end
        end else begin
            checkOutput("bram_we_idle", DW'(bram_we), '0);
        end
`ifdef RV_IOPMP_BRAM_ARB_PERF_EN
        checkOutput("conflict_cnt", DW'(conflict_cnt), DW'(m_conf));
`else
        checkOutput("conflict_cnt", DW'(conflict_cnt), '0);
`endif
        resp.lk_v  = g_lk;
        resp.cfg_v = g_cfg && !cw;
        resp.data  = g_lk ? shadow[la] : shadow[ca];
        sb.push_back(resp);
        if (g_cfg && cw)
            for (int b = 0; b < BW; b++)
                if (cb[b]) shadow[ca][b*8 +: 8] = cd[b*8 +: 8];
        if (r) begin
            m_force = 1'b0;
            m_stall = 0;
            m_conf  = '0;
        end else begin
            if (ce && lr) m_conf = m_conf + 32'd1;
            nxt = (!ce || g_cfg) ? 0 : ((m_stall < MS) ? m_stall + 1 : MS);
            if (!m_force && nxt == MS) m_force = 1'b1;
            else if (m_force && g_cfg) m_force = 1'b0;
            m_stall = nxt;
        end
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic bothReq(input logic [AW-1:0] ca, input logic [AW-1:0] la);
        applyStimulus(1'b0, 1'b1, 1'b0, ca, '0, '0, 1'b1, la);
    endtask

    logic          r_ce, r_cw, r_lr;
    logic [AW-1:0] r_ca, r_la;
    logic [DW-1:0] r_cd;
    logic [BW-1:0] r_cb;

    initial begin
        rst = 1'b1; cfg_en = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_din = '0; cfg_be = '0;
        lk_req = 1'b0; lk_addr = '0; bram_dout = '0;
        for (int i = 0; i < NE; i++) begin
            mem[i]    = initWord(i);
            shadow[i] = initWord(i);
        end

        doReset();
        doReset();

        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 3'd3);
        checkOutput("first_lk_gnt", DW'(lk_gnt), DW'(1'b1));
        checkOutput("first_lk_addr", DW'(bram_addr), DW'(3'd3));
        checkOutput("first_lk_we", DW'(bram_we), '0);
        idle();
        checkOutput("first_lk_rdata", lk_rdata, initWord(3));

        applyStimulus(1'b0, 1'b1, 1'b1, 3'd5, {4{32'hDEAD_BEEF}}, 16'hFFFF, 1'b0, '0);
        checkOutput("wr_gnt", DW'(cfg_gnt), DW'(1'b1));
        checkOutput("wr_we", DW'(bram_we), DW'(1'b1));
        checkOutput("wr_be", DW'(bram_be), DW'(16'hFFFF));
        idle();
        checkOutput("wr_no_rvalid", DW'(cfg_rvalid), '0);

        // Partial write followed immediately by a lookup of the same entry
        applyStimulus(1'b0, 1'b1, 1'b1, 3'd6, {4{32'h1234_5678}}, 16'h00F0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 3'd6);
        idle();
        checkOutput("raw_rdata", lk_rdata, {initWord(6)[DW-1:64], 32'h1234_5678, initWord(6)[31:0]});
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd5, '0, '0, 1'b0, '0);
        idle();
        checkOutput("cfg_rd_rdata", cfg_rdata, {4{32'hDEAD_BEEF}});

        // Sustained contention: cfg forced through on every fifth cycle
        doReset();
        for (int i = 0; i < 10; i++) begin
            bothReq(3'd2, 3'(i));
            checkOutput($sformatf("starve_cfg_gnt_%0d", i), DW'(cfg_gnt), DW'(i == 4 || i == 9));
            checkOutput($sformatf("starve_lk_gnt_%0d", i), DW'(lk_gnt), DW'(i != 4 && i != 9));
        end
        idle();
`ifdef RV_IOPMP_BRAM_ARB_PERF_EN
        checkOutput("conflict_10", DW'(conflict_cnt), DW'(32'd10));
`else
        checkOutput("conflict_10", DW'(conflict_cnt), '0);
`endif

        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 3'd1);
        doReset();
        checkOutput("rst_lk_rvalid", DW'(lk_rvalid), '0);
        idle();
        checkOutput("post_rst_lk_rvalid", DW'(lk_rvalid), '0);
        for (int i = 0; i < 5; i++) begin
            bothReq(3'd4, 3'd0);
            checkOutput($sformatf("post_rst_cfg_gnt_%0d", i), DW'(cfg_gnt), DW'(i == 4));
        end

        doReset();
        bothReq(3'd1, 3'd2);
        bothReq(3'd1, 3'd2);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 3'd2);
        for (int i = 0; i < 5; i++) begin
            bothReq(3'd1, 3'd7);
            checkOutput($sformatf("restall_cfg_gnt_%0d", i), DW'(cfg_gnt), DW'(i == 4));
        end

        // Random traffic; each requester holds its request until the model says it was granted
        r_ce = 1'b0; r_cw = 1'b0; r_ca = '0; r_cd = '0; r_cb = '0; r_lr = 1'b0; r_la = '0;
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 59) == 0), r_ce, r_cw, r_ca, r_cd, r_cb, r_lr, r_la);
            if (g_cfg || !r_ce || rst) begin
                r_ce = ($urandom_range(0, 2) != 0);
                r_cw = $urandom_range(0, 1) == 1;
                r_ca = AW'($urandom_range(0, NE - 1));
                r_cd = {$urandom, $urandom, $urandom, $urandom};
                r_cb = BW'($urandom);
            end
            if (g_lk || !r_lr || rst) begin
                r_lr = ($urandom_range(0, 3) != 0);
                r_la = AW'($urandom_range(0, NE - 1));
            end
        end
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_iopmp_bram_arbiter.md
RV_IOPMP_BRAM_ARBITER -- requirements
Module: rv_iopmp_bram_arbiter

Interface
REQ-001 SHALL have parameter NUMBER_ENTRIES, default 8, number of 128-bit entry words in the BRAM.
REQ-002 SHALL have parameter BRAM_DWIDTH, default 128, BRAM data width in bits.
REQ-003 SHALL have parameter MAX_STALL, default 4, maximum consecutive cycles a pending cfg request may be denied.
REQ-004 SHALL have port clk_i  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have cfg ports from the width converter: cfg_en_i in 1, cfg_we_i in 1, cfg_addr_i in clog2(NUMBER_ENTRIES), cfg_din_i in BRAM_DWIDTH, cfg_be_i in BRAM_DWIDTH/8.
REQ-007 SHALL have cfg response ports: cfg_gnt_o out 1 (request accepted this cycle), cfg_rvalid_o out 1 (read data valid), cfg_rdata_o out BRAM_DWIDTH.
REQ-008 SHALL have lookup (entry walker) ports: lk_req_i in 1, lk_addr_i in clog2(NUMBER_ENTRIES), lk_gnt_o out 1, lk_rvalid_o out 1, lk_rdata_o out BRAM_DWIDTH; lookup is read-only.
REQ-009 SHALL have BRAM ports: bram_en_o, bram_we_o out 1; bram_addr_o out clog2(NUMBER_ENTRIES); bram_din_o out BRAM_DWIDTH; bram_be_o out BRAM_DWIDTH/8; bram_dout_i in BRAM_DWIDTH.
REQ-010 SHALL have port conflict_cnt_o  out  32  count of cycles both requesters were pending.

Function
REQ-011 SHALL grant at most one requester per cycle; grant combinational from current requests and registered state.
REQ-012 SHALL drive bram_* combinationally from the granted requester; bram_en_o=0, bram_we_o=0 when none granted.
REQ-013 SHALL force bram_we_o=0 and bram_be_o=0 for lookup grants.
REQ-014 SHALL return read data exactly 1 cycle after grant: registered owner flag selects lk_rvalid_o or cfg_rvalid_o; both rdata outputs carry bram_dout_i.
REQ-015 SHALL NOT assert cfg_rvalid_o for granted writes.
REQ-016 SHALL require requesters to hold en/req and payload stable until gnt; arbiter does not buffer requests.
REQ-017 SHALL use FSM states ST_NORMAL and ST_CFG_FORCE; ST_NORMAL: lookup wins on simultaneous requests; ST_CFG_FORCE: cfg wins.
REQ-018 SHALL keep stall counter (clog2(MAX_STALL+1) bits): increments each cycle cfg pending and denied, saturates at MAX_STALL, clears on cfg grant or cfg_en_i=0.
REQ-019 SHALL transition ST_NORMAL->ST_CFG_FORCE when stall counter reaches MAX_STALL; ST_CFG_FORCE->ST_NORMAL on cfg grant.
REQ-020 SHALL grant the sole requester immediately in either state (no idle bubbles).
REQ-021 SHALL treat lookup read and cfg write to same address in consecutive cycles as ordered by grant; no bypass.
REQ-022 SHALL increment conflict_cnt_o when cfg_en_i and lk_req_i both high; wraps 0xFFFFFFFF->0.

Reset
REQ-023 SHALL on rst_i=1: state ST_NORMAL, stall counter 0, owner flag cleared, conflict_cnt_o 0, all gnt/rvalid 0.
REQ-024 SHALL drop any rvalid pending from the cycle before reset; rvalid outputs 0 in the cycle after reset.
REQ-025 SHALL hold all grants 0 while rst_i=1.

Configuration
REQ-026 SHALL compile conflict counter only with RV_IOPMP_BRAM_ARB_PERF_EN defined; without it conflict_cnt_o tied to 0 and no counter flops exist; arbitration unchanged.

Structure
REQ-027 SHALL place FSM state enum and owner encoding typedef in rv_iopmp_pkg.
REQ-028 SHALL implement as one module; no sub-module.

Verification
REQ-029 Reset then lk_req_i=1 addr 3 -> lk_gnt_o=1 same cycle, bram_addr_o=3, bram_we_o=0; next cycle lk_rvalid_o=1, lk_rdata_o=bram_dout_i.
REQ-030 cfg write addr 5, be 0xFFFF, no lookup -> cfg_gnt_o=1, bram_we_o=1, bram_be_o=0xFFFF; cfg_rvalid_o stays 0.
REQ-031 lk_req_i and cfg read held high continuously, MAX_STALL=4 -> lookup granted 4 cycles, cfg granted 5th cycle, then lookup resumes.
REQ-032 Simultaneous requests 10 cycles, RV_IOPMP_BRAM_ARB_PERF_EN defined -> conflict_cnt_o=10; undefined -> conflict_cnt_o=0.
REQ-033 rst_i asserted the cycle after a lookup grant -> lk_rvalid_o=0 the following cycle, state ST_NORMAL, stall counter 0.
REQ-034 cfg_en_i dropped after 2 denied cycles, reasserted -> stall counter restarts from 0; force after 4 further denials.
